// File: rtl/mic4_readout.sv
// Readout controller for the MIC4 chip: parallel-loads the chip, clocks serial
// words out MSB first and hands each word downstream over a valid/ready pair.
module mic4_readout #(
  parameter int DIV_WIDTH    = 6,
  parameter int WORD_WIDTH   = 16,
  parameter int NWORDS_WIDTH = 10
) (
  input  logic                    clk_in,
  input  logic                    rst,
  input  logic [DIV_WIDTH-1:0]    div,
  input  logic [NWORDS_WIDTH-1:0] nwords,
  input  logic                    start,
  input  logic                    sdata_in,
  input  logic                    data_ready,
  output logic                    sclk_out,
  output logic                    load_out,
  output logic [WORD_WIDTH-1:0]   data_out,
  output logic                    data_valid,
  output logic                    busy,
  output logic                    done
);
  localparam int BIT_W = (WORD_WIDTH > 1) ? $clog2(WORD_WIDTH) : 1;
  localparam logic [BIT_W-1:0]        LAST_BIT = BIT_W'(WORD_WIDTH - 1);
  localparam logic [BIT_W-1:0]        BIT_ONE  = BIT_W'(1);
  localparam logic [DIV_WIDTH:0]      CNT_ONE  = (DIV_WIDTH+1)'(1);
  localparam logic [NWORDS_WIDTH-1:0] WORD_ONE = NWORDS_WIDTH'(1);

  typedef enum logic [2:0] {IDLE, LOAD, SHIFT, HOLD, DONE} state_t;

  state_t                  state;
  logic [DIV_WIDTH-1:0]    div_l;
  logic [NWORDS_WIDTH-1:0] nwords_l;
  logic [NWORDS_WIDTH-1:0] word_cnt;
  logic [DIV_WIDTH:0]      cnt;
  logic [BIT_W-1:0]        bit_cnt;
  logic [WORD_WIDTH-2:0]   shreg;
  logic                    sdata_p0;
  logic                    sdata_p1;
  logic [DIV_WIDTH:0]      rise_cnt;
  logic [DIV_WIDTH:0]      last_cnt;
  logic [WORD_WIDTH-1:0]   word_next;

  // Divisors below 2 would leave too little high time for the synchronizer.
  function automatic logic [DIV_WIDTH-1:0] eff_div(input logic [DIV_WIDTH-1:0] d);
    return (d < DIV_WIDTH'(2)) ? DIV_WIDTH'(2) : d;
  endfunction

  // With H = D+1, sclk rises after count D and the bit period ends at count 2D+1.
  assign rise_cnt  = {1'b0, div_l};
  assign last_cnt  = {div_l, 1'b1};
  assign word_next = {shreg, sdata_p1};

  // Stage p0/p1: two-flop synchronizer for the chip's asynchronous serial data
  always_ff @(posedge clk_in or posedge rst) begin
    if (rst) begin
      sdata_p0 <= 1'b0;
      sdata_p1 <= 1'b0;
    end else begin
      sdata_p0 <= sdata_in;
      sdata_p1 <= sdata_p0;
    end
  end

  always_ff @(posedge clk_in or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      div_l      <= '0;
      nwords_l   <= '0;
      word_cnt   <= '0;
      cnt        <= '0;
      bit_cnt    <= '0;
      shreg      <= '0;
      sclk_out   <= 1'b0;
      load_out   <= 1'b0;
      data_out   <= '0;
      data_valid <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            div_l    <= eff_div(div);
            nwords_l <= nwords;
            word_cnt <= '0;
            cnt      <= '0;
            bit_cnt  <= '0;
            busy     <= 1'b1;
            if (nwords != '0) begin
              state    <= LOAD;
              load_out <= 1'b1;
            end else begin
              state <= DONE;
              done  <= 1'b1;
            end
          end
        end
        LOAD: begin
          if (cnt == last_cnt) begin
            cnt      <= '0;
            load_out <= 1'b0;
            state    <= SHIFT;
          end else begin
            cnt <= cnt + CNT_ONE;
          end
        end
        SHIFT: begin
          if (cnt == rise_cnt) sclk_out <= 1'b1;
          // Last cycle of the high phase: take the bit and drop sclk.
          if (cnt == last_cnt) begin
            sclk_out <= 1'b0;
            cnt      <= '0;
            shreg    <= word_next[WORD_WIDTH-2:0];
            if (bit_cnt == LAST_BIT) begin
              bit_cnt    <= '0;
              data_out   <= word_next;
              data_valid <= 1'b1;
              state      <= HOLD;
            end else begin
              bit_cnt <= bit_cnt + BIT_ONE;
            end
          end else begin
            cnt <= cnt + CNT_ONE;
          end
        end
        HOLD: begin
          if (data_valid && data_ready) begin
            data_valid <= 1'b0;
            word_cnt   <= word_cnt + WORD_ONE;
            if (word_cnt == nwords_l - WORD_ONE) begin
              state <= DONE;
              done  <= 1'b1;
            end else begin
              state <= SHIFT;
              cnt   <= '0;
            end
          end
        end
        DONE: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mic4_readout.sv
// Directed bench for mic4_readout: a chip model shifts known words on sclk
// rising edges and each step checks outputs against hand-computed values.
module tb_mic4_readout;
  logic        clk_in = 1'b0;
  logic        rst;
  logic [5:0]  div;
  logic [9:0]  nwords;
  logic        start;
  logic        sdata_in = 1'b0;
  logic        data_ready;
  logic        sclk_out;
  logic        load_out;
  logic [15:0] data_out;
  logic        data_valid;
  logic        busy;
  logic        done;

  mic4_readout #(.DIV_WIDTH(6), .WORD_WIDTH(16), .NWORDS_WIDTH(10)) dut (
    .clk_in(clk_in), .rst(rst), .div(div), .nwords(nwords), .start(start),
    .sdata_in(sdata_in), .data_ready(data_ready), .sclk_out(sclk_out),
    .load_out(load_out), .data_out(data_out), .data_valid(data_valid),
    .busy(busy), .done(done)
  );

  always #2 clk_in = ~clk_in;

  int total = 0;
  int bad   = 0;

  // Chip model: load rewinds the stream, each sclk rising edge presents the next bit.
  logic [63:0] chip_stream = 64'h0;
  int          chip_bit = 0;
  always @(posedge sclk_out or posedge load_out) begin
    if (load_out) chip_bit = 0;
    else begin
      sdata_in = (chip_bit < 64) ? chip_stream[63 - chip_bit] : 1'b0;
      chip_bit++;
    end
  end

  // Monitor samples the cycle that ends at each rising clock edge.
  int          cyc = 0, n_load = 0, n_done = 0, n_rise = 0;
  int          last_rise = 0, rise_period = 0, stab_err = 0;
  logic        sclk_prev = 1'b0, prev_valid = 1'b0, prev_ready = 1'b0;
  logic [15:0] prev_data = 16'h0;
  logic [15:0] got[$];
  always @(posedge clk_in) begin
    cyc++;
    if (load_out === 1'b1) n_load++;
    if (done === 1'b1) n_done++;
    if (sclk_out === 1'b1 && sclk_prev === 1'b0) begin
      n_rise++;
      rise_period = cyc - last_rise;
      last_rise   = cyc;
    end
    sclk_prev = sclk_out;
    if (prev_valid && !prev_ready && (data_valid !== 1'b1 || data_out !== prev_data)) stab_err++;
    if (data_valid === 1'b1 && data_ready === 1'b1) got.push_back(data_out);
    prev_valid = (data_valid === 1'b1);
    prev_ready = data_ready;
    prev_data  = data_out;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [15:0] word_at(input int idx);
    if (idx < got.size()) return got[idx];
    return 16'hxxxx;
  endfunction

  task automatic idle(input int n);
    repeat (n) @(negedge clk_in);
  endtask

  task automatic start_frame(input logic [5:0] dv, input logic [9:0] nw, input logic [63:0] stream);
    div = dv; nwords = nw; chip_stream = stream; start = 1'b1;
    @(negedge clk_in);
    start = 1'b0;
  endtask

  task automatic wait_done(input string tag, input int budget);
    int base, i;
    base = n_done; i = 0;
    while (n_done == base && i < budget) begin
      @(negedge clk_in);
      i++;
    end
    check({tag, "_done_seen"}, 32'(n_done - base), 32'd1);
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    int b_load, b_done, b_rise, b_got, k;
    rst = 1'b1; div = '0; nwords = '0; start = 1'b0; data_ready = 1'b1;
    idle(3);
    check("rst_sclk", sclk_out, 0);
    check("rst_load", load_out, 0);
    check("rst_data", data_out, 0);
    check("rst_valid", data_valid, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    rst = 1'b0;
    idle(2);

    // Two words at div=4: H=5, load lasts 10 cycles
    b_load = n_load; b_done = n_done; b_got = got.size();
    start_frame(6'd4, 10'd2, {16'hA5C3, 16'h1234, 32'h0});
    check("t1_busy", busy, 1);
    check("t1_load", load_out, 1);
    wait_done("t1", 2000);
    check("t1_busy_after", busy, 0);
    idle(3);
    check("t1_load_cycles", 32'(n_load - b_load), 10);
    check("t1_done_pulses", 32'(n_done - b_done), 1);
    check("t1_nwords", 32'(got.size() - b_got), 2);
    check("t1_word0", word_at(b_got), 16'hA5C3);
    check("t1_word1", word_at(b_got + 1), 16'h1234);

    // div=0 clamps to D=2: 6-cycle sclk period
    b_rise = n_rise; b_got = got.size(); b_load = n_load;
    start_frame(6'd0, 10'd1, {16'hBEEF, 48'h0});
    wait_done("t2", 1000);
    check("t2_rises", 32'(n_rise - b_rise), 16);
    check("t2_period", 32'(rise_period), 6);
    check("t2_load_cycles", 32'(n_load - b_load), 6);
    check("t2_word", word_at(b_got), 16'hBEEF);

    // nwords=0: done right after start, no load, no sclk
    b_load = n_load; b_rise = n_rise; b_done = n_done;
    start_frame(6'd5, 10'd0, 64'h0);
    check("t3_done", done, 1);
    check("t3_busy", busy, 1);
    check("t3_load", load_out, 0);
    @(negedge clk_in);
    check("t3_done_low", done, 0);
    check("t3_busy_low", busy, 0);
    idle(5);
    check("t3_load_cycles", 32'(n_load - b_load), 0);
    check("t3_rises", 32'(n_rise - b_rise), 0);
    check("t3_done_pulses", 32'(n_done - b_done), 1);

    // Backpressure: ready low 50 cycles after the first word
    data_ready = 1'b0; b_got = got.size();
    start_frame(6'd2, 10'd2, {16'h5A5A, 16'hC3C3, 32'h0});
    k = 0;
    while (data_valid !== 1'b1 && k < 2000) begin
      @(negedge clk_in);
      k++;
    end
    check("t4_valid", data_valid, 1);
    check("t4_first", data_out, 16'h5A5A);
    b_rise = n_rise;
    idle(50);
    check("t4_sclk_held", sclk_out, 0);
    check("t4_rises_held", 32'(n_rise - b_rise), 0);
    check("t4_data_held", data_out, 16'h5A5A);
    check("t4_valid_held", data_valid, 1);
    check("t4_no_xfer", 32'(got.size() - b_got), 0);
    data_ready = 1'b1;
    wait_done("t4", 2000);
    check("t4_nwords", 32'(got.size() - b_got), 2);
    check("t4_word0", word_at(b_got), 16'h5A5A);
    check("t4_word1", word_at(b_got + 1), 16'hC3C3);
    check("t4_stable", 32'(stab_err), 0);

    // Mid-frame start/div/nwords changes ignored: done 34H+1=137 edges after accept (H=4)
    b_got = got.size(); b_done = n_done; b_load = n_load;
    div = 6'd3; nwords = 10'd1; chip_stream = {16'h0F0F, 48'h0}; start = 1'b1;
    @(negedge clk_in);
    start = 1'b0; k = 0;
    while (done !== 1'b1 && k < 1000) begin
      @(negedge clk_in);
      k++;
      if (k == 40) begin start = 1'b1; div = 6'd9; nwords = 10'd5; end
      if (k == 41) start = 1'b0;
    end
    check("t5_latency", 32'(k), 137);
    idle(5);
    check("t5_done_pulses", 32'(n_done - b_done), 1);
    check("t5_load_cycles", 32'(n_load - b_load), 8);
    check("t5_nwords", 32'(got.size() - b_got), 1);
    check("t5_word", word_at(b_got), 16'h0F0F);
    check("t5_busy", busy, 0);

    // Reset during word 1 shift aborts without done; next frame is clean
    start_frame(6'd2, 10'd2, {16'h1357, 16'h2468, 32'h0});
    b_rise = n_rise; k = 0;
    while ((n_rise - b_rise) < 5 && k < 1000) begin
      @(negedge clk_in);
      k++;
    end
    check("t6_busy_pre", busy, 1);
    b_done = n_done;
    rst = 1'b1;
    #1;
    check("t6_rst_sclk", sclk_out, 0);
    check("t6_rst_load", load_out, 0);
    check("t6_rst_data", data_out, 0);
    check("t6_rst_valid", data_valid, 0);
    check("t6_rst_busy", busy, 0);
    check("t6_rst_done", done, 0);
    idle(3);
    rst = 1'b0;
    idle(3);
    check("t6_no_done", 32'(n_done - b_done), 0);
    b_got = got.size();
    start_frame(6'd2, 10'd2, {16'h1357, 16'h9BDF, 32'h0});
    wait_done("t6", 2000);
    check("t6_nwords", 32'(got.size() - b_got), 2);
    check("t6_word0", word_at(b_got), 16'h1357);
    check("t6_word1", word_at(b_got + 1), 16'h9BDF);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mic4_readout.md
MIC4_READOUT -- requirements
Module: mic4_readout

Interface
REQ-001 SHALL have parameter DIV_WIDTH, default 6, width of the bit-period division factor.
REQ-002 SHALL have parameter WORD_WIDTH, default 16, bits per deserialized word.
REQ-003 SHALL have parameter NWORDS_WIDTH, default 10, width of the word-count request.
REQ-004 SHALL have port clk_in, input, 1, the single block clock (250 MHz).
REQ-005 SHALL have port rst, input, 1, reset, asynchronous, active-high.
REQ-006 SHALL have port div, input, DIV_WIDTH, half bit period minus one, in clk_in cycles.
REQ-007 SHALL have port nwords, input, NWORDS_WIDTH, number of words to read per frame.
REQ-008 SHALL have port start, input, 1, single-cycle frame request.
REQ-009 SHALL have port sdata_in, input, 1, chip serial data output, asynchronous to clk_in.
REQ-010 SHALL have port data_ready, input, 1, downstream accepts data_out.
REQ-011 SHALL have port sclk_out, output, 1, readout shift clock to chip.
REQ-012 SHALL have port load_out, output, 1, parallel-load strobe to chip.
REQ-013 SHALL have port data_out, output, WORD_WIDTH, deserialized word.
REQ-014 SHALL have port data_valid, output, 1, data_out holds an unaccepted word.
REQ-015 SHALL have port busy, output, 1, frame in progress.
REQ-016 SHALL have port done, output, 1, one-cycle end-of-frame pulse.

Function
REQ-017 SHALL implement FSM states IDLE, LOAD, SHIFT, HOLD, DONE.
REQ-018 SHALL use effective divisor D = max(div, 2); half period H = D+1 cycles; bit period 2H cycles.
REQ-019 SHALL latch div and nwords on the accepted start; changes mid-frame SHALL have no effect.
REQ-020 SHALL pass sdata_in through a 2-flop synchronizer before any use.
REQ-021 IDLE: start with nwords>0 -> LOAD, busy=1 next cycle; start with nwords=0 -> DONE directly, no load_out, no sclk_out edges.
REQ-022 SHALL ignore start whenever busy=1.
REQ-023 LOAD: load_out=1 and sclk_out=0 for exactly 2H cycles, then -> SHIFT.
REQ-024 SHIFT: sclk_out low H cycles then high H cycles per bit; bit sampled from synchronizer output on the last cycle of the high phase.
REQ-025 SHALL shift bits MSB first; WORD_WIDTH samples form one word.
REQ-026 After the last bit of a word: data_out updated and data_valid=1 on the next cycle, state -> HOLD.
REQ-027 HOLD: sclk_out=0, no sampling; transfer occurs on the cycle data_valid=1 and data_ready=1; data_valid falls the following cycle.
REQ-028 After transfer: if words transferred = latched nwords -> DONE, else -> SHIFT with fresh prescaler (low phase starts).
REQ-029 data_ready high while entering HOLD SHALL give a one-cycle HOLD (no extra stall).
REQ-030 data_out SHALL stay stable while data_valid=1.
REQ-031 DONE: done=1 for one cycle, busy=0 on the following cycle, -> IDLE.
REQ-032 Word counter SHALL be NWORDS_WIDTH wide; nwords = 2^NWORDS_WIDTH-1 SHALL complete without wrap.

Reset
REQ-033 rst=1 SHALL immediately force: state IDLE, sclk_out=0, load_out=0, data_out=0, data_valid=0, busy=0, done=0, counters and synchronizer 0.
REQ-034 rst asserted mid-frame SHALL abort the frame with no done pulse; the first start after release SHALL begin a clean frame.

Verification
REQ-035 div=4, nwords=2, data_ready=1, chip model shifts 0xA5C3 then 0x1234 on sclk rising edge -> load_out high 10 cycles, data_out 0xA5C3 then 0x1234, one done pulse.
REQ-036 div=0 -> sclk period 6 cycles (D=2), words received correctly.
REQ-037 nwords=0 start -> done 1 cycle after start, load_out and sclk_out never toggle.
REQ-038 data_ready held low 50 cycles after first word -> sclk_out held low, data_out stable, no bit lost; second word correct after release.
REQ-039 start pulsed again while busy, and div changed mid-frame -> ignored, frame timing unchanged.
REQ-040 rst pulsed during SHIFT of word 1 -> all outputs reset at once, no done; next start reads full frame correctly.
